// File: rtl/match_timer_pkg.sv
// Shared game package: timer state encoding, timing defaults
// and the top-level game state constants.
package match_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HOLD    = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_t;

    localparam int          FRAMES_PER_SEC_DEF = 60;
    localparam logic [7:0]  MAX_TIME_BCD_DEF   = 8'h99;

    localparam logic [1:0]  GS_MENU = 2'd0;
    localparam logic [1:0]  GS_PLAY = 2'd1;
    localparam logic [1:0]  GS_OVER = 2'd2;

endpackage

// File: rtl/match_timer_bcd_incr2.sv
// Two-digit BCD +1; saturates at 99 and flags it.
// Pure combinational so the score display can reuse it.
module bcd_incr2 (
    input  logic [7:0] i_val,
    output logic [7:0] o_val,
    output logic       o_sat
);

    // Ones digit rolls 9->0 with carry into tens; 99 holds.
    always_comb begin
        o_sat = (i_val == 8'h99);
        o_val = i_val;
        if (!o_sat) begin
            if (i_val[3:0] >= 4'd9) begin
                o_val[3:0] = 4'd0;
                o_val[7:4] = i_val[7:4] + 4'd1;
            end else begin
                o_val[3:0] = i_val[3:0] + 4'd1;
            end
        end
    end

endmodule

// File: rtl/match_timer.sv
// Elapsed match timer: counts frame ticks into BCD seconds,
// freezes on game over, expires at the terminal time.
module match_timer
    import match_timer_pkg::*;
#(
    parameter int         FRAMES_PER_SEC = FRAMES_PER_SEC_DEF,
    parameter logic [7:0] MAX_TIME_BCD   = MAX_TIME_BCD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       game_start,
    input  logic       game_over,
    input  logic       clear,
    output logic [7:0] time_counter,
    output logic       second_pulse,
    output logic       time_up,
    output logic       running
);

    localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

    timer_state_t  r_state;
    timer_state_t  w_state_nx;
    logic [FW-1:0] r_frame;
    logic [FW-1:0] w_frame_nx;
    logic [7:0]    r_time;
    logic [7:0]    w_time_nx;
    logic          r_pulse;
    logic          w_pulse_nx;
    logic          r_running;
    logic          r_time_up;
    logic [7:0]    w_inc;
    logic          w_sat;
    logic          w_last;

    bcd_incr2 u_incr (
        .i_val (r_time),
        .o_val (w_inc),
        .o_sat (w_sat)
    );

    assign w_last = (r_frame == FW'(FRAMES_PER_SEC - 1));

    // Next state and counters; clear > game_over > second > start.
    always_comb begin
        w_state_nx = r_state;
        w_frame_nx = r_frame;
        w_time_nx  = r_time;
        w_pulse_nx = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_frame_nx = '0;
                w_time_nx  = 8'h00;
                if (!clear && !game_over && game_start)
                    w_state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (clear) begin
                    w_state_nx = ST_IDLE;
                    w_frame_nx = '0;
                    w_time_nx  = 8'h00;
                end else if (game_over) begin
                    w_state_nx = ST_HOLD;
                end else if (frame_tick) begin
                    if (w_last) begin
                        w_frame_nx = '0;
                        w_time_nx  = w_inc;
                        w_pulse_nx = 1'b1;
                        if (w_inc == MAX_TIME_BCD || w_sat)
                            w_state_nx = ST_EXPIRED;
                    end else begin
                        w_frame_nx = r_frame + 1'b1;
                    end
                end
            end
            ST_HOLD, ST_EXPIRED: begin
                if (clear) begin
                    w_state_nx = ST_IDLE;
                    w_frame_nx = '0;
                    w_time_nx  = 8'h00;
                end
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_frame   <= '0;
            r_time    <= 8'h00;
            r_pulse   <= 1'b0;
            r_running <= 1'b0;
            r_time_up <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_frame   <= w_frame_nx;
            r_time    <= w_time_nx;
            r_pulse   <= w_pulse_nx;
            r_running <= (w_state_nx == ST_RUN);
            r_time_up <= (w_state_nx == ST_EXPIRED);
        end
    end

    assign time_counter = r_time;
    assign second_pulse = r_pulse;
    assign time_up      = r_time_up;
    assign running      = r_running;

endmodule

// File: tb/tb_match_timer.sv
// Self-checking bench for match_timer against an integer
// seconds/frames model of the timer rules.
module tb_match_timer;

    localparam int FPS = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       game_start = 1'b0;
    logic       game_over = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] time_counter;
    logic       second_pulse;
    logic       time_up;
    logic       running;

    int total = 0;
    int bad = 0;

    // model: 0 idle, 1 run, 2 hold, 3 expired
    int m_mode = 0;
    int m_frames = 0;
    int m_secs = 0;
    bit m_pulse = 1'b0;

    match_timer dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .game_start   (game_start),
        .game_over    (game_over),
        .clear        (clear),
        .time_counter (time_counter),
        .second_pulse (second_pulse),
        .time_up      (time_up),
        .running      (running)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] exp_vec();
        logic [7:0] b;
        b[7:4] = 4'(m_secs / 10);
        b[3:0] = 4'(m_secs % 10);
        return {b, m_pulse, m_mode == 3, m_mode == 1};
    endfunction

    function automatic logic [10:0] got_vec();
        return {time_counter, second_pulse, time_up, running};
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_frames = 0;
        m_secs = 0;
        m_pulse = 1'b0;
    endtask

    task automatic model_step(input bit ft, gs, go, cl);
        m_pulse = 1'b0;
        if (cl) begin
            model_reset();
        end else if (m_mode == 0) begin
            if (gs && !go) m_mode = 1;
        end else if (m_mode == 1) begin
            if (go) begin
                m_mode = 2;
            end else if (ft) begin
                m_frames++;
                if (m_frames == FPS) begin
                    m_frames = 0;
                    m_secs++;
                    m_pulse = 1'b1;
                    if (m_secs == 99) m_mode = 3;
                end
            end
        end
    endtask

    task automatic cyc(input bit ft, gs, go, cl);
        frame_tick = ft;
        game_start = gs;
        game_over = go;
        clear = cl;
        @(posedge clk);
        model_step(ft, gs, go, cl);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #3;
        total++;
        if (got_vec() !== 11'h0) begin
            bad++;
            $display("FAIL reset got=%h want=000", got_vec());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
        total++;
        if (got_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL no_start got=%h want=%h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_first_second();
        int np = 0;
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 60; i++) begin
            cyc(1, 0, 0, 0);
            if (second_pulse) np++;
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL first_sec[%0d] got=%h want=%h", i, got_vec(), exp_vec());
            end
        end
        total++;
        if (np != 1 || time_counter !== 8'h01) begin
            bad++;
            $display("FAIL first_sec_end pulses=%0d t=%h want 1 01", np, time_counter);
        end
    endtask

    task automatic test_bcd_carry();
        int errs = 0;
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 599; i++) begin
            cyc(1, 0, 0, 0);
            if (got_vec() !== exp_vec() || time_counter[3:0] > 4'd9) errs++;
        end
        total++;
        if (errs != 0 || time_counter !== 8'h09) begin
            bad++;
            $display("FAIL carry_09 errs=%0d t=%h want 09", errs, time_counter);
        end
        cyc(1, 0, 0, 0);
        total++;
        if (time_counter !== 8'h10 || !second_pulse) begin
            bad++;
            $display("FAIL carry_10 t=%h p=%b want 10 1", time_counter, second_pulse);
        end
    endtask

    task automatic test_expire();
        int errs = 0;
        int np = 0;
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 99 * FPS; i++) begin
            cyc(1, 0, 0, 0);
            if (got_vec() !== exp_vec() || time_counter[3:0] > 4'd9) errs++;
        end
        total++;
        if (errs != 0 || time_counter !== 8'h99 || time_up !== 1'b1 || running !== 1'b0) begin
            bad++;
            $display("FAIL expire errs=%0d t=%h up=%b run=%b want 99 1 0", errs, time_counter, time_up, running);
        end
        for (int i = 0; i < 200; i++) begin
            cyc(1, $urandom_range(0, 1), 0, 0);
            if (second_pulse) np++;
            if (time_counter !== 8'h99 || !time_up) errs++;
        end
        total++;
        if (errs != 0 || np != 0) begin
            bad++;
            $display("FAIL expire_hold errs=%0d pulses=%0d want 0 0", errs, np);
        end
    endtask

    task automatic test_hold();
        int errs = 0;
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 42 * FPS + 30; i++) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        total++;
        if (time_counter !== 8'h42 || running || time_up || second_pulse) begin
            bad++;
            $display("FAIL hold_enter got=%h want=%h", got_vec(), {8'h42, 3'b000});
        end
        for (int i = 0; i < 100; i++) begin
            cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0);
            if (got_vec() !== exp_vec() || time_counter !== 8'h42) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL hold_frozen errs=%0d want 0", errs);
        end
        cyc(0, 0, 0, 1);
        total++;
        if (got_vec() !== 11'h0) begin
            bad++;
            $display("FAIL hold_clear got=%h want=000", got_vec());
        end
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 60; i++) cyc(1, 0, 0, 0);
        total++;
        if (time_counter !== 8'h01 || !running) begin
            bad++;
            $display("FAIL hold_restart t=%h run=%b want 01 1", time_counter, running);
        end
    endtask

    task automatic test_slow_tick();
        int first = -1;
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        for (int k = 0; k < 400 && first < 0; k++) begin
            cyc((k % 4) == 3, 0, 0, 0);
            if (second_pulse) first = k + 1;
        end
        total++;
        if (first != 240) begin
            bad++;
            $display("FAIL slow_tick first_pulse_cycle=%0d want 240", first);
        end
    endtask

    task automatic test_rollover_gameover();
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 98 * FPS + 59; i++) cyc(1, 0, 0, 0);
        total++;
        if (time_counter !== 8'h98) begin
            bad++;
            $display("FAIL pre_roll t=%h want 98", time_counter);
        end
        cyc(1, 0, 1, 0);
        total++;
        if (got_vec() !== exp_vec() || time_counter !== 8'h98 || time_up || running) begin
            bad++;
            $display("FAIL roll_gameover got=%h want=%h", got_vec(), {8'h98, 3'b000});
        end
    endtask

    task automatic test_back_to_back();
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 30; i++) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 29; i++) cyc(1, 0, 0, 0);
        total++;
        if (time_counter !== 8'h01 || !second_pulse) begin
            bad++;
            $display("FAIL restart_ignored t=%h p=%b want 01 1", time_counter, second_pulse);
        end
    endtask

    task automatic test_async_reset();
        int errs = 0;
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 17 * FPS + 30; i++) cyc(1, 0, 0, 0);
        total++;
        if (time_counter !== 8'h17 || !running) begin
            bad++;
            $display("FAIL pre_rst t=%h run=%b want 17 1", time_counter, running);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if (got_vec() !== 11'h0) begin
            bad++;
            $display("FAIL async_rst got=%h want=000", got_vec());
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc(1, 0, 0, 0);
            if (got_vec() !== 11'h0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL post_rst_idle errs=%0d want 0", errs);
        end
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 60; i++) cyc(1, 0, 0, 0);
        total++;
        if (time_counter !== 8'h01) begin
            bad++;
            $display("FAIL post_rst_count t=%h want 01", time_counter);
        end
    endtask

    task automatic test_random();
        bit go = 1'b0;
        bit ft;
        bit gs;
        bit cl;
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 6000; i++) begin
            ft = ($urandom_range(0, 3) != 0);
            gs = ($urandom_range(0, 19) == 0);
            cl = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 199) == 0) go = ~go;
            cyc(ft, gs, go, cl);
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random[%0d] got=%h want=%h", i, got_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_second();
        test_bcd_carry();
        test_expire();
        test_hold();
        test_slow_tick();
        test_rollover_gameover();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/match_timer.md
MATCH_TIMER -- requirements
Module: match_timer

Interface
REQ-001 SHALL have parameter FRAMES_PER_SEC, default 60, meaning frame_tick pulses per elapsed game second.
REQ-002 SHALL have parameter MAX_TIME_BCD, default 8'h99, meaning the terminal two-digit BCD time.
REQ-003 SHALL have port clk, input, 1, the single system clock, with every flop on its rising edge.
REQ-004 SHALL have port rst, input, 1, the asynchronous active-high reset.
REQ-005 SHALL have port frame_tick, input, 1, a one-cycle frame enable; tied high when clk is itself the 60 Hz frame clock.
REQ-006 SHALL have port game_start, input, 1, a one-cycle pulse from the game state machine marking the start of play.
REQ-007 SHALL have port game_over, input, 1, a level from the game state machine; high means the match has ended.
REQ-008 SHALL have port clear, input, 1, a one-cycle pulse on return to menu.
REQ-009 SHALL have port time_counter, output, 8, the elapsed time as BCD, tens in [7:4] and ones in [3:0].
REQ-010 SHALL have port second_pulse, output, 1, a one-cycle strobe each time time_counter increments.
REQ-011 SHALL have port time_up, output, 1, a level that is high while the timer is in EXPIRED.
REQ-012 SHALL have port running, output, 1, a level that is high while the timer is in RUN.

Function
REQ-013 SHALL implement states IDLE, RUN, HOLD and EXPIRED.
REQ-014 SHALL, in IDLE, hold time_counter=8'h00 and the frame counter at 0, and move to RUN on game_start.
REQ-015 SHALL, in RUN, advance the frame counter by 1 only on cycles with frame_tick=1; frame_tick=0 holds all counters.
REQ-016 SHALL, when the frame counter is at FRAMES_PER_SEC-1 and frame_tick=1, wrap the frame counter to 0, BCD-increment time_counter and assert second_pulse on the following cycle only.
REQ-017 SHALL BCD-increment as follows: ones 9 goes to 0 with tens+1; the ones nibble never exceeds 9; no binary values 0xA-0xF ever appear.
REQ-018 SHALL, when time_counter reaches MAX_TIME_BCD, enter EXPIRED in the same cycle the value is registered: time_up=1, time_counter frozen at 8'h99, no wrap to 00.
REQ-019 SHALL, on game_over=1 in RUN, enter HOLD with time_counter frozen, no second_pulse, and the frame counter frozen.
REQ-020 SHALL, in HOLD and EXPIRED, ignore frame_tick and game_start, and return to IDLE (counters zeroed) on clear.
REQ-021 SHALL apply priority clear > game_over > second increment > game_start when inputs coincide in one cycle.
REQ-022 SHALL, for game_over and a final-second rollover to 99 in the same cycle, enter HOLD with time_counter at its pre-increment value and time_up=0.
REQ-023 SHALL, for clear in RUN, return to IDLE immediately, zero all counters, and not assert second_pulse.
REQ-024 SHALL, for game_start while already in RUN, be ignored with no restart.
REQ-025 SHALL drive all outputs from registers with no combinational input-to-output path; latency is 1 cycle from the triggering edge.
REQ-026 SHALL size the frame counter as clog2(FRAMES_PER_SEC) bits.

Reset
REQ-027 SHALL, on rst=1 asynchronously, set state=IDLE, frame counter=0, time_counter=8'h00, second_pulse=0, time_up=0 and running=0.
REQ-028 SHALL, on rst asserted mid-RUN, abandon the count with no residual pulse after release.
REQ-029 SHALL, after rst deasserts, require a new game_start before counting resumes.

Structure
REQ-030 SHALL place the state encoding (2-bit: IDLE, RUN, HOLD, EXPIRED), the default FRAMES_PER_SEC value and MAX_TIME_BCD in the shared game package, together with the game_state constants.
REQ-031 SHALL instantiate one sub-module, bcd_incr2, a combinational two-digit BCD +1 with saturation flag, reusable by the score display.

Verification
REQ-032 SHALL cover: rst, game_start, frame_tick=1 for 60 cycles -> second_pulse exactly once, time_counter=8'h01.
REQ-033 SHALL cover: run 599 ticks from 00 -> 8'h09; one more tick -> 8'h10, never 8'h0A.
REQ-034 SHALL cover: run to 99 s -> time_up=1, running=0, time_counter stays 8'h99 for 200 further ticks, no second_pulse.
REQ-035 SHALL cover: game_over at 8'h42 with frame count 30 -> HOLD, value 8'h42 held; clear -> 8'h00, IDLE; game_start -> counts from 00.
REQ-036 SHALL cover: frame_tick toggling every 4 cycles -> first second_pulse after 240 clk cycles; and game_over coincident with rollover 98->99 -> HOLD at 8'h98, time_up=0.
REQ-037 SHALL cover: rst pulse mid-second at 8'h17 -> all outputs 0 immediately (asynchronously); no counting without a new game_start.
